// File: rtl/xy_noc_pkg.sv
// Shared XY NoC definitions: default field widths, packet layout, error bit indices.
// Packet layout is {xaddr[MSB], yaddr, data[LSB]}.
package xy_noc_pkg;

  localparam int XADDR_W = 4;
  localparam int YADDR_W = 4;
  localparam int DATA_W  = 8;
  localparam int PCKT_W  = XADDR_W + YADDR_W + DATA_W;

  localparam int DATA_LSB  = 0;
  localparam int YADDR_LSB = DATA_W;
  localparam int XADDR_LSB = DATA_W + YADDR_W;

  localparam int ERR_SW_OVF   = 0;
  localparam int ERR_MISROUTE = 1;

  typedef struct packed {
    logic [XADDR_W-1:0] xaddr;
    logic [YADDR_W-1:0] yaddr;
    logic [DATA_W-1:0]  data;
  } hdr_t;

  function automatic logic [PCKT_W-1:0] pack_pckt(input logic [XADDR_W-1:0] x,
                                                  input logic [YADDR_W-1:0] y,
                                                  input logic [DATA_W-1:0]  d);
    return {x, y, d};
  endfunction

  function automatic hdr_t unpack_pckt(input logic [PCKT_W-1:0] p);
    return hdr_t'(p);
  endfunction

endpackage

// File: rtl/xy_ni_fifo.sv
// Synchronous FIFO, 2**DEPTH_W entries; head is combinational from the read pointer (0 when empty).
// Latency: a push at edge N is visible at the head during cycle N+1.
// Backpressure: push refused while full, pop ignored while empty; both judged pre-edge.
module xy_ni_fifo #(
  parameter int W       = 16,
  parameter int DEPTH_W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);

  logic [DEPTH_W:0] wptr, rptr;
  logic [W-1:0]     mem [2**DEPTH_W];

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_W] != rptr[DEPTH_W]) &&
                 (wptr[DEPTH_W-1:0] == rptr[DEPTH_W-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + 1'b1;
      if (pop && !empty)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full)
      mem[wptr[DEPTH_W-1:0]] <= wr_dat;
  end

  assign head_dat = empty ? '0 : mem[rptr[DEPTH_W-1:0]];

endmodule

// File: rtl/xy_resource_ni.sv
// PE <-> xy_switch RESOURCE-port NI: packs/buffers TX messages, buffers/checks RX packets.
// Latency: PE accept at edge N -> sw_wr_en_o in cycle N+1; switch write at N -> rx_valid_o in N+1.
// Backpressure: tx_ready_o = TX FIFO not full; injection held off by sw_fifo_full_i; RX drops when full. XY_NI_STATS_EN adds counters.
module xy_resource_ni
  import xy_noc_pkg::*;
#(
  parameter int X_CORD       = 0,
  parameter int Y_CORD       = 0,
  parameter int FIFO_DEPTH_W = 2,
  parameter int PCKT_XADDR_W = XADDR_W,
  parameter int PCKT_YADDR_W = YADDR_W,
  parameter int PCKT_DATA_W  = DATA_W,
  parameter int PCKT_W       = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [PCKT_XADDR_W-1:0] tx_xaddr_i,
  input  logic [PCKT_YADDR_W-1:0] tx_yaddr_i,
  input  logic [PCKT_DATA_W-1:0]  tx_data_i,
  output logic                    sw_wr_en_o,
  output logic [PCKT_W-1:0]       sw_pckt_o,
  input  logic                    sw_fifo_full_i,
  input  logic                    sw_fifo_overflow_i,
  input  logic                    sw_wr_en_i,
  input  logic [PCKT_W-1:0]       sw_pckt_i,
  output logic                    rx_fifo_full_o,
  output logic                    rx_fifo_overflow_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic [PCKT_XADDR_W-1:0] rx_xaddr_o,
  output logic [PCKT_YADDR_W-1:0] rx_yaddr_o,
  output logic [PCKT_DATA_W-1:0]  rx_data_o,
  output logic [1:0]              err_o,
  output logic [15:0]             tx_cnt_o,
  output logic [15:0]             rx_cnt_o
);

  logic              tx_full, tx_empty, tx_push;
  logic [PCKT_W-1:0] tx_head;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [PCKT_W-1:0] rx_head;
  logic              misroute;
  logic              rx_ovf_q;
  logic [1:0]        err_q;

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && !tx_full;
  assign sw_wr_en_o = !tx_empty && !sw_fifo_full_i;
  assign sw_pckt_o  = tx_head;

  xy_ni_fifo #(.W(PCKT_W), .DEPTH_W(FIFO_DEPTH_W)) u_tx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (tx_push),
    .wr_dat   ({tx_xaddr_i, tx_yaddr_i, tx_data_i}),
    .pop      (sw_wr_en_o),
    .full     (tx_full),
    .empty    (tx_empty),
    .head_dat (tx_head)
  );

  assign rx_push = sw_wr_en_i && !rx_full;
  assign rx_pop  = !rx_empty && rx_ready_i;

  xy_ni_fifo #(.W(PCKT_W), .DEPTH_W(FIFO_DEPTH_W)) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (rx_push),
    .wr_dat   (sw_pckt_i),
    .pop      (rx_pop),
    .full     (rx_full),
    .empty    (rx_empty),
    .head_dat (rx_head)
  );

  assign rx_fifo_full_o     = rx_full;
  assign rx_fifo_overflow_o = rx_ovf_q;
  assign rx_valid_o         = !rx_empty;
  assign {rx_xaddr_o, rx_yaddr_o, rx_data_o} = rx_head;

  // Misrouted packets are still delivered; only the sticky flag records them.
  assign misroute =
    (sw_pckt_i[PCKT_W-1 -: PCKT_XADDR_W]      != PCKT_XADDR_W'(X_CORD)) ||
    (sw_pckt_i[PCKT_DATA_W +: PCKT_YADDR_W]   != PCKT_YADDR_W'(Y_CORD));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_ovf_q <= 1'b0;
      err_q    <= '0;
    end else begin
      rx_ovf_q <= sw_wr_en_i && rx_full;
      if (sw_fifo_overflow_i)
        err_q[ERR_SW_OVF] <= 1'b1;
      if (rx_push && misroute)
        err_q[ERR_MISROUTE] <= 1'b1;
    end
  end

  assign err_o = err_q;

`ifdef XY_NI_STATS_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (sw_wr_en_o && tx_cnt_q != 16'hFFFF)
        tx_cnt_q <= tx_cnt_q + 16'd1;
      if (rx_pop && rx_cnt_q != 16'hFFFF)
        rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign tx_cnt_o = tx_cnt_q;
  assign rx_cnt_o = rx_cnt_q;
`else
  assign tx_cnt_o = '0;
  assign rx_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xy_resource_ni.sv
// Bench for xy_resource_ni at node (1,1): directed plan steps plus a random phase, checked each cycle
// against a queue-based model of the NI's observable behaviour.
module tb_xy_resource_ni;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [3:0]  tx_xaddr_i, tx_yaddr_i;
  logic [7:0]  tx_data_i;
  logic        sw_wr_en_o;
  logic [15:0] sw_pckt_o;
  logic        sw_fifo_full_i, sw_fifo_overflow_i;
  logic        sw_wr_en_i;
  logic [15:0] sw_pckt_i;
  logic        rx_fifo_full_o, rx_fifo_overflow_o, rx_valid_o, rx_ready_i;
  logic [3:0]  rx_xaddr_o, rx_yaddr_o;
  logic [7:0]  rx_data_o;
  logic [1:0]  err_o;
  logic [15:0] tx_cnt_o, rx_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [1:0]  m_err;
  logic        m_ovf;
  int          m_txcnt, m_rxcnt;

  always #5 clk_i = ~clk_i;

  xy_resource_ni #(.X_CORD(1), .Y_CORD(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_xaddr_i(tx_xaddr_i), .tx_yaddr_i(tx_yaddr_i), .tx_data_i(tx_data_i),
    .sw_wr_en_o(sw_wr_en_o), .sw_pckt_o(sw_pckt_o),
    .sw_fifo_full_i(sw_fifo_full_i), .sw_fifo_overflow_i(sw_fifo_overflow_i),
    .sw_wr_en_i(sw_wr_en_i), .sw_pckt_i(sw_pckt_i),
    .rx_fifo_full_o(rx_fifo_full_o), .rx_fifo_overflow_o(rx_fifo_overflow_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_xaddr_o(rx_xaddr_o), .rx_yaddr_o(rx_yaddr_o), .rx_data_o(rx_data_o),
    .err_o(err_o), .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int c);
`ifdef XY_NI_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_err   = 2'b00;
    m_ovf   = 1'b0;
    m_txcnt = 0;
    m_rxcnt = 0;
  endtask

  task automatic check_all();
    logic [15:0] rh;
    rh = (rxq.size() > 0) ? rxq[0] : 16'h0;
    chk("tx_ready", 32'(tx_ready_o), 32'(txq.size() < DEPTH));
    chk("sw_wr_en", 32'(sw_wr_en_o), 32'(txq.size() > 0 && !sw_fifo_full_i));
    chk("sw_pckt", 32'(sw_pckt_o), 32'((txq.size() > 0) ? txq[0] : 16'h0));
    chk("rx_valid", 32'(rx_valid_o), 32'(rxq.size() > 0));
    chk("rx_full", 32'(rx_fifo_full_o), 32'(rxq.size() == DEPTH));
    chk("rx_ovf", 32'(rx_fifo_overflow_o), 32'(m_ovf));
    chk("rx_pckt", 32'({rx_xaddr_o, rx_yaddr_o, rx_data_o}), 32'(rh));
    chk("err", 32'(err_o), 32'(m_err));
    chk("tx_cnt", 32'(tx_cnt_o), 32'(cnt_exp(m_txcnt)));
    chk("rx_cnt", 32'(rx_cnt_o), 32'(cnt_exp(m_rxcnt)));
  endtask

  // Entered just after a negedge: drive, check, advance the model, move to the next negedge.
  task automatic cyc(input logic tv, input logic [3:0] xa, input logic [3:0] ya, input logic [7:0] d,
                     input logic sf, input logic so, input logic sw, input logic [15:0] sp,
                     input logic rr);
    logic acc, inj, del, rpush;
    tx_valid_i = tv; tx_xaddr_i = xa; tx_yaddr_i = ya; tx_data_i = d;
    sw_fifo_full_i = sf; sw_fifo_overflow_i = so; sw_wr_en_i = sw; sw_pckt_i = sp;
    rx_ready_i = rr;
    #1;
    check_all();
    acc   = tv && txq.size() < DEPTH;
    inj   = txq.size() > 0 && !sf;
    del   = rxq.size() > 0 && rr;
    rpush = sw && rxq.size() < DEPTH;
    m_ovf = sw && rxq.size() == DEPTH;
    if (inj) begin void'(txq.pop_front()); if (m_txcnt < 65535) m_txcnt++; end
    if (acc) txq.push_back({xa, ya, d});
    if (del) begin void'(rxq.pop_front()); if (m_rxcnt < 65535) m_rxcnt++; end
    if (rpush) begin
      rxq.push_back(sp);
      if (sp[15:12] != 4'd1 || sp[11:8] != 4'd1) m_err[1] = 1'b1;
    end
    if (so) m_err[0] = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input logic sf, input logic rr);
    cyc(1'b0, 4'h0, 4'h0, 8'h00, sf, 1'b0, 1'b0, 16'h0, rr);
  endtask

  initial begin
    rst_ni = 1'b0;
    tx_valid_i = 0; tx_xaddr_i = 0; tx_yaddr_i = 0; tx_data_i = 0;
    sw_fifo_full_i = 0; sw_fifo_overflow_i = 0; sw_wr_en_i = 0; sw_pckt_i = 0; rx_ready_i = 0;
    model_reset();
    @(negedge clk_i);
    #1 check_all();
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single message to (2,1): appears on sw_pckt_o one cycle later.
    cyc(1'b1, 4'd2, 4'd1, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("first_pkt", 32'(sw_pckt_o), 32'h21A5);
    idle(1'b0, 1'b0);

    // Switch full: 5 offers, only 4 fit; then release and drain.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 4'd3, 4'd0, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("tx_full_ready", 32'(tx_ready_o), 32'h0);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);

    // RX at node (1,1): addressed packet, then misrouted packet.
    cyc(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h113C, 1'b0);
    chk("rx_own_data", 32'(rx_data_o), 32'h3C);
    cyc(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h213C, 1'b1);
    idle(1'b0, 1'b1);
    chk("misroute_err", 32'(err_o[1]), 32'h1);
    idle(1'b0, 1'b1);

    // RX overflow: 5 writes with PE stalled, then drain.
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 16'(16'h1140 + i), 1'b0);
    chk("rx_ovf_pulse", 32'(rx_fifo_overflow_o), 32'h1);
    for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);

    // Switch overflow pulse sets a sticky error.
    cyc(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    chk("sw_ovf_sticky", 32'(err_o[0]), 32'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] sp;
      sp = ($urandom_range(0, 3) != 0) ? {8'h11, 8'($urandom)} : 16'($urandom);
      cyc(1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 80) == 0),
          1'($urandom), sp, 1'($urandom));
    end

    // Reset mid-burst with both FIFOs loaded: outputs clear before the next clock edge.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'd1, 4'd1, 8'(i), 1'b1, 1'b0, 1'b1, 16'(16'h1190 + i), 1'b0);
    chk("pre_reset_loaded", 32'(rx_valid_o && !tx_empty_probe()), 32'h1);
    #2 rst_ni = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1'b0, 1'b0);
    cyc(1'b1, 4'd1, 4'd1, 8'h77, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    idle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Switch-side view of TX occupancy: the head is shown only when something is queued.
  function automatic logic tx_empty_probe();
    return txq.size() == 0;
  endfunction

endmodule
